instr_fetch: RTL

Program-counter and fetch-register stage sitting directly in front of the instruction ROM: drives its `addr`, captures the returned `instr`/`imm` pair and hands it to decode through a valid/ready register. Owns sequential PC advance (1 or 2 words per instruction), branch redirect with flush, halt detection and back-pressure from decode.

---
 rtl/project_pkg.sv | 24 ++
 rtl/instr_fetch.sv | 138 +++++++++++++
 2 files changed

// File: rtl/project_pkg.sv
// Shared CPU types: machine word, ROM size, fetch-stage encodings.
// Word widths here set every datapath width in the fetch stage.
package project_pkg;

    localparam int word_size = 8;
    localparam int rom_size  = 64;

    typedef logic [word_size-1:0] word;

    // Any instruction with all mask bits set carries an immediate in the next word.
    localparam word IMM_MASK   = 8'hC0;
    localparam word HALT_INSTR = 8'h3F;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_e;

    function automatic logic is_two_word(input word w);
        return (w & IMM_MASK) == IMM_MASK;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// PC and fetch register ahead of the instruction ROM: addr registered, instruction on f_* one cycle later, f_* held while !f_ready.
// FETCH_BOUNDS_EN: an out-of-ROM fetch halts the stage with a sticky fault instead of loading.
module instr_fetch
    import project_pkg::*;
#(
    parameter word RESET_PC  = '0,
    parameter int  ROM_WORDS = rom_size
) (
    input  logic clk,
    input  logic rst_n,
    output word  addr,
    input  word  instr,
    input  word  imm,
    input  logic br_valid,
    input  word  br_target,
    output logic f_valid,
    input  logic f_ready,
    output word  f_instr,
    output word  f_imm,
    output word  f_pc,
    output logic f_has_imm,
    output logic halted,
    output logic fault
);

`ifdef FETCH_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    // One extra bit so pc+1 at the top of the address space cannot wrap past the limit.
    localparam logic [word_size:0] ROM_LIMIT = (word_size+1)'(ROM_WORDS);
    localparam logic [word_size:0] ONE_EXT   = (word_size+1)'(1);

    fetch_state_e state_q, state_d;
    word          pc_q, pc_d;
    logic         f_valid_q, f_valid_d;
    word          f_instr_q, f_instr_d;
    word          f_imm_q, f_imm_d;
    word          f_pc_q, f_pc_d;
    logic         f_has_imm_q, f_has_imm_d;
    logic         fault_q, fault_d;

    logic               has_imm;
    logic               advance;
    logic               redirect;
    logic               oob;
    logic [word_size:0] pc_ext;

    assign has_imm  = is_two_word(instr);
    assign redirect = br_valid && (state_q != BOOT);
    assign advance  = (state_q == RUN) && (!f_valid_q || f_ready) && !br_valid;
    assign pc_ext   = {1'b0, pc_q};
    assign oob      = BOUNDS_EN &&
                      ((pc_ext >= ROM_LIMIT) || (has_imm && ((pc_ext + ONE_EXT) >= ROM_LIMIT)));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        f_valid_d   = f_valid_q;
        f_instr_d   = f_instr_q;
        f_imm_d     = f_imm_q;
        f_pc_d      = f_pc_q;
        f_has_imm_d = f_has_imm_q;
        fault_d     = fault_q;

        if (redirect) begin
            pc_d      = br_target;
            f_valid_d = 1'b0;
            state_d   = RUN;
            fault_d   = 1'b0;
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (advance) begin
                        if (oob) begin
                            f_valid_d = 1'b0;
                            fault_d   = 1'b1;
                            state_d   = HALT;
                        end else begin
                            f_valid_d   = 1'b1;
                            f_instr_d   = instr;
                            f_imm_d     = has_imm ? imm : '0;
                            f_has_imm_d = has_imm;
                            f_pc_d      = pc_q;
                            // The halt instruction is delivered but the PC parks on it.
                            if (instr == HALT_INSTR) begin
                                state_d = HALT;
                            end else begin
                                pc_d = pc_q + (has_imm ? word'(2) : word'(1));
                            end
                        end
                    end
                end
                HALT: begin
                    if (f_valid_q && f_ready) begin
                        f_valid_d = 1'b0;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            f_valid_q   <= 1'b0;
            f_instr_q   <= '0;
            f_imm_q     <= '0;
            f_pc_q      <= '0;
            f_has_imm_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            f_valid_q   <= f_valid_d;
            f_instr_q   <= f_instr_d;
            f_imm_q     <= f_imm_d;
            f_pc_q      <= f_pc_d;
            f_has_imm_q <= f_has_imm_d;
            fault_q     <= fault_d;
        end
    end

    assign addr      = pc_q;
    assign f_valid   = f_valid_q;
    assign f_instr   = f_instr_q;
    assign f_imm     = f_imm_q;
    assign f_pc      = f_pc_q;
    assign f_has_imm = f_has_imm_q;
    assign halted    = (state_q == HALT);
    assign fault     = BOUNDS_EN ? fault_q : 1'b0;

endmodule
